// File: rtl/mem_stage_lsu_if.sv
// Bundle of the memory stage's handshake and data buses: execute-side input,
// data-SRAM response, writeback-side output and decode forwarding.
interface mem_stage_lsu_if #(
    parameter int ES_TO_MS_BUS_WD = 77,
    parameter int MS_TO_WS_BUS_WD = 71,
    parameter int MS_TO_DS_BUS_WD = 39
);
    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       data_sram_data_ok;
    logic [31:0]                data_sram_rdata;
    logic                       ws_allowin;
    logic                       ws_block;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus;
    logic                       ms_ex;

    // The memory stage itself.
    modport slave (
        input  es_to_ms_valid, es_to_ms_bus,
        input  data_sram_data_ok, data_sram_rdata,
        input  ws_allowin, ws_block,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus, ms_ex
    );

    // The surrounding pipeline that drives the stage.
    modport master (
        output es_to_ms_valid, es_to_ms_bus,
        output data_sram_data_ok, data_sram_rdata,
        output ws_allowin, ws_block,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus, ms_ex
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-access pipeline stage. Holds one instruction, waits for the data-SRAM
// response of a load/store issued in execute, aligns and extends load data,
// buffers a response that arrives while writeback stalls and discards the
// responses of requests whose instructions were flushed.
module mem_stage_lsu #(
    parameter int ES_TO_MS_BUS_WD = 77,
    parameter int MS_TO_WS_BUS_WD = 71,
    parameter int MS_TO_DS_BUS_WD = 39
) (
    input  logic            clk,
    input  logic            reset,
    mem_stage_lsu_if.slave  lsu
);

    logic                       ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] ms_bus;
    logic                       rdata_buf_valid;
    logic [31:0]                rdata_buf;
    logic [1:0]                 drop_cnt;

    logic        ms_ex_f;
    logic [2:0]  ms_ld_op;
    logic        ms_mem_wait;
    logic [1:0]  ms_vaddr_lo;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_alu_result;
    logic [31:0] ms_pc;

    logic        es_mem_wait;
    logic        data_ok_live;
    logic        ms_ready_go;
    logic        ms_leave_ok;
    logic        entry_block;
    logic        ms_allowin_i;
    logic        ms_moves_out;
    logic        drop_inc;
    logic        drop_dec;
    logic [31:0] load_word;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] final_result;
    logic        fwd_we;
    logic        ms_load_stall;

    assign {ms_ex_f, ms_ld_op, ms_mem_wait, ms_vaddr_lo, ms_gr_we,
            ms_dest, ms_alu_result, ms_pc} = ms_bus;

    assign es_mem_wait = lsu.es_to_ms_bus[72];

    // A response only belongs to the current instruction once every stale
    // response owed to flushed instructions has been discarded.
    assign data_ok_live = lsu.data_sram_data_ok & (drop_cnt == 2'd0);

    // An excepted instruction never issued a request, so it never waits.
    assign ms_ready_go = !ms_mem_wait | ms_ex_f | rdata_buf_valid | data_ok_live;

    // The stage can be vacated this cycle; kept separate from ms_allowin so a
    // blocked memory op in execute cannot make the current occupant linger
    // after writeback has already taken it.
    assign ms_leave_ok  = !ms_valid | (ms_ready_go & lsu.ws_allowin);
    assign entry_block  = (drop_cnt != 2'd0) & lsu.es_to_ms_valid & es_mem_wait;
    assign ms_allowin_i = ms_leave_ok & !entry_block;
    assign ms_moves_out = ms_valid & ms_ready_go & lsu.ws_allowin;

    assign drop_inc = lsu.ws_block & ms_valid & ms_mem_wait & !ms_ex_f &
                      !rdata_buf_valid & !lsu.data_sram_data_ok;
    assign drop_dec = lsu.data_sram_data_ok & (drop_cnt != 2'd0);

    // Instruction-valid flag: flush wins, otherwise refill whenever the stage empties.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (lsu.ws_block) begin
            ms_valid <= 1'b0;
        end else if (ms_leave_ok) begin
            ms_valid <= lsu.es_to_ms_valid & !entry_block;
        end
    end

    // Bus register: capture the execute payload on a successful handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_bus <= '0;
        end else if (lsu.es_to_ms_valid && ms_allowin_i) begin
            ms_bus <= lsu.es_to_ms_bus;
        end
    end

    // Response buffer: hold read data that arrives while writeback is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_buf_valid <= 1'b0;
            rdata_buf       <= 32'd0;
        end else if (lsu.ws_block || ms_moves_out) begin
            rdata_buf_valid <= 1'b0;
        end else if (data_ok_live && ms_valid && ms_mem_wait &&
                     !lsu.ws_allowin && !rdata_buf_valid) begin
            rdata_buf_valid <= 1'b1;
            rdata_buf       <= lsu.data_sram_rdata;
        end
    end

    // Count responses still owed to flushed requests; saturates at 3.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= 2'd0;
        end else if (drop_inc && !drop_dec) begin
            if (drop_cnt != 2'd3) begin
                drop_cnt <= drop_cnt + 2'd1;
            end
        end else if (drop_dec && !drop_inc) begin
            drop_cnt <= drop_cnt - 2'd1;
        end
    end

    // Select the byte/half lane addressed by the low address bits and extend it.
    always_comb begin
        load_word = rdata_buf_valid ? rdata_buf : lsu.data_sram_rdata;
        load_byte = load_word[7:0];
        case (ms_vaddr_lo)
            2'd0:    load_byte = load_word[7:0];
            2'd1:    load_byte = load_word[15:8];
            2'd2:    load_byte = load_word[23:16];
            default: load_byte = load_word[31:24];
        endcase
        load_half    = ms_vaddr_lo[1] ? load_word[31:16] : load_word[15:0];
        final_result = ms_alu_result;
        if (!ms_ex_f) begin
            case (ms_ld_op)
                3'b001:  final_result = {{24{load_byte[7]}}, load_byte};
                3'b010:  final_result = {24'd0, load_byte};
                3'b011:  final_result = {{16{load_half[15]}}, load_half};
                3'b100:  final_result = {16'd0, load_half};
                3'b101:  final_result = load_word;
                default: final_result = ms_alu_result;
            endcase
        end
    end

    assign fwd_we        = ms_valid & ms_gr_we & !ms_ex_f;
    assign ms_load_stall = ms_valid & (ms_ld_op != 3'b000) & !ms_ready_go;

    assign lsu.ms_allowin     = ms_allowin_i;
    assign lsu.ms_to_ws_valid = ms_valid & ms_ready_go & !lsu.ws_block;
    assign lsu.ms_to_ws_bus   = {ms_ex_f, ms_gr_we, ms_dest, final_result, ms_pc};
    assign lsu.ms_to_ds_bus   = {fwd_we, ms_dest, final_result, ms_load_stall};
    assign lsu.ms_ex          = ms_valid & ms_ex_f;

endmodule
